// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, state encoding and address-split helpers for
// the direct-mapped instruction cache.
//   ICACHE_LINES        number of one-word lines (power of two)
//   ICACHE_INDEX_WIDTH  log2(ICACHE_LINES)
//   ICACHE_ADDR_WIDTH   PC / memory address width
//   ICACHE_TAG_WIDTH    stored tag width (address minus index minus byte offset)
package icache_pkg;

  localparam int ICACHE_LINES       = 256;
  localparam int ICACHE_INDEX_WIDTH = 8;
  localparam int ICACHE_ADDR_WIDTH  = 32;
  localparam int ICACHE_TAG_WIDTH   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_t;

  // Line index: the word address bits just above the byte offset.
  function automatic logic [ICACHE_INDEX_WIDTH-1:0] pc_index(
    input logic [ICACHE_ADDR_WIDTH-1:0] pc
  );
    return pc[ICACHE_INDEX_WIDTH+1:2];
  endfunction

  // Tag: everything above the index.
  function automatic logic [ICACHE_TAG_WIDTH-1:0] pc_tag(
    input logic [ICACHE_ADDR_WIDTH-1:0] pc
  );
    return pc[ICACHE_ADDR_WIDTH-1:ICACHE_INDEX_WIDTH+2];
  endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the instruction cache.
// Combinational read on rd_index, synchronous single-line write, and
// synchronous clear of all valid bits on rst. Writes are frozen while rdy=0.
//   clk, rst, rdy               clock, sync active-high reset, global ready
//   rd_index                    line being looked up
//   rd_valid, rd_tag, rd_data   contents of that line
//   wr_en, wr_index             write strobe and target line
//   wr_tag, wr_data             tag and instruction word to store
module icache_array
  import icache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [ICACHE_INDEX_WIDTH-1:0] rd_index,
  output logic                          rd_valid,
  output logic [ICACHE_TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [ICACHE_INDEX_WIDTH-1:0] wr_index,
  input  logic [ICACHE_TAG_WIDTH-1:0]   wr_tag,
  input  logic [31:0]                   wr_data
);

  logic [ICACHE_LINES-1:0]     valid_bits;
  logic [ICACHE_TAG_WIDTH-1:0] tag_mem  [ICACHE_LINES];
  logic [31:0]                 data_mem [ICACHE_LINES];

  // Only the valid bits need a reset; tag/data are meaningless until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (rdy && wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Kept reset-free so the tag/data storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rdy && wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between the
// fetcher and memCtrl. Hits answer one cycle after acceptance; a miss issues
// a single word request, fills the line on return and answers the cycle after.
// A rob misbranch aborts an in-flight miss without touching the array.
//   clk, rst, rdy                       clock, sync active-high reset, global ready
//   in_fetch_valid, in_fetch_pc         fetch request (sampled while out_fetch_ready)
//   out_fetch_ready                     cache idle and accepting a request
//   out_fetch_valid, out_fetch_instr    one-cycle response pulse and instruction
//   out_mem_req, out_mem_addr           miss request to memCtrl, held until in_mem_valid
//   in_mem_valid, in_mem_instr          memCtrl returned word
//   in_misbranch                        rob flush
module icache
  import icache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         in_fetch_valid,
  input  logic [ICACHE_ADDR_WIDTH-1:0] in_fetch_pc,
  output logic                         out_fetch_ready,
  output logic                         out_fetch_valid,
  output logic [31:0]                  out_fetch_instr,
  output logic                         out_mem_req,
  output logic [ICACHE_ADDR_WIDTH-1:0] out_mem_addr,
  input  logic                         in_mem_valid,
  input  logic [31:0]                  in_mem_instr,
  input  logic                         in_misbranch
);

  icache_state_t                state;
  logic                         rd_valid;
  logic [ICACHE_TAG_WIDTH-1:0]  rd_tag;
  logic [31:0]                  rd_data;
  logic                         hit;
  logic                         fill;

  // The latched miss address lives in out_mem_addr, so the fill target is
  // derived from it rather than from a separate copy of the PC.
  icache_array u_array (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rd_index (pc_index(in_fetch_pc)),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_index (pc_index(out_mem_addr)),
    .wr_tag   (pc_tag(out_mem_addr)),
    .wr_data  (in_mem_instr)
  );

  assign hit  = rd_valid && (rd_tag == pc_tag(in_fetch_pc));

  // A misbranch in the return cycle discards the word entirely.
  assign fill = !rst && (state == ICACHE_MISS) && in_mem_valid && !in_misbranch;

  assign out_fetch_ready = (state == ICACHE_IDLE);

  // Misbranch beats every state action: it drops the miss and also swallows
  // a request presented in the same cycle, so no response can follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ICACHE_IDLE;
      out_fetch_valid <= 1'b0;
      out_fetch_instr <= '0;
      out_mem_req     <= 1'b0;
      out_mem_addr    <= '0;
    end else if (rdy) begin
      out_fetch_valid <= 1'b0;
      if (in_misbranch) begin
        state       <= ICACHE_IDLE;
        out_mem_req <= 1'b0;
      end else begin
        case (state)
          ICACHE_IDLE: begin
            if (in_fetch_valid) begin
              if (hit) begin
                out_fetch_valid <= 1'b1;
                out_fetch_instr <= rd_data;
              end else begin
                out_mem_req  <= 1'b1;
                out_mem_addr <= in_fetch_pc & ~ICACHE_ADDR_WIDTH'(3);
                state        <= ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            if (in_mem_valid) begin
              out_fetch_valid <= 1'b1;
              out_fetch_instr <= in_mem_instr;
              out_mem_req     <= 1'b0;
              state           <= ICACHE_IDLE;
            end
          end
          default: state <= ICACHE_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache. The driver consults a behavioural
// cache model (plain arrays keyed by word address) to decide hit or miss and
// pushes the expected miss address / instruction into queues; an independent
// negedge monitor pops and compares whenever the DUT presents a response or
// a memory request.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_fetch_valid;
  logic [31:0] in_fetch_pc;
  logic        out_fetch_ready;
  logic        out_fetch_valid;
  logic [31:0] out_fetch_instr;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic        in_mem_valid;
  logic [31:0] in_mem_instr;
  logic        in_misbranch;

  always #5 clk = ~clk;

  icache dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_fetch_valid  (in_fetch_valid),
    .in_fetch_pc     (in_fetch_pc),
    .out_fetch_ready (out_fetch_ready),
    .out_fetch_valid (out_fetch_valid),
    .out_fetch_instr (out_fetch_instr),
    .out_mem_req     (out_mem_req),
    .out_mem_addr    (out_mem_addr),
    .in_mem_valid    (in_mem_valid),
    .in_mem_instr    (in_mem_instr),
    .in_misbranch    (in_misbranch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] resp_q[$];
  logic [31:0] req_q[$];
  bit          mon_en   = 1'b0;
  bit          prev_req = 1'b0;

  // Reference model: which word address each of the 256 lines holds.
  bit          m_valid [256];
  logic [31:0] m_addr  [256];
  logic [31:0] m_data  [256];
  logic [31:0] mem_over [logic [31:0]];

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return (pc / 4) * 4;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] pc);
    logic [31:0] a;
    a = word_addr(pc);
    if (mem_over.exists(a)) return mem_over[a];
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (out_fetch_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) checkOutput("ready_timeout", 32'(out_fetch_ready), 32'd1);
  endtask

  // mb_mode: 0 none, 1 misbranch with the request, 2 misbranch with the memory return.
  task automatic applyStimulus(input logic [31:0] pc, input int delay,
                               input int mb_mode, input int stall);
    int          idx;
    bit          hit;
    logic [31:0] w;
    waitReady();
    idx = line_of(pc);
    hit = m_valid[idx] && (m_addr[idx] == word_addr(pc));
    in_fetch_valid = 1'b1;
    in_fetch_pc    = pc;
    if (mb_mode == 1) begin
      in_misbranch = 1'b1;
      step();
      in_misbranch   = 1'b0;
      in_fetch_valid = 1'b0;
      return;
    end
    if (hit) begin
      resp_q.push_back(m_data[idx]);
      step();
      in_fetch_valid = 1'b0;
      return;
    end
    req_q.push_back(word_addr(pc));
    step();
    in_fetch_valid = 1'b0;
    if (stall > 0) begin
      rdy = 1'b0;
      repeat (stall) step();
      rdy = 1'b1;
    end
    repeat (delay) step();
    w = mem_val(pc);
    in_mem_valid = 1'b1;
    in_mem_instr = w;
    if (mb_mode == 2) begin
      in_misbranch = 1'b1;
    end else begin
      resp_q.push_back(w);
      m_valid[idx] = 1'b1;
      m_addr[idx]  = word_addr(pc);
      m_data[idx]  = w;
    end
    step();
    in_mem_valid = 1'b0;
    in_misbranch = 1'b0;
    in_mem_instr = $urandom;
    checkOutput("ready_after_miss", 32'(out_fetch_ready), 32'd1);
  endtask

  task automatic resetMidMiss();
    waitReady();
    in_fetch_valid = 1'b1;
    in_fetch_pc    = 32'h0000_0300;
    req_q.push_back(32'h0000_0300);
    step();
    in_fetch_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    checkOutput("rst_mid_fetch_valid", 32'(out_fetch_valid), 32'd0);
    checkOutput("rst_mid_mem_req", 32'(out_mem_req), 32'd0);
    checkOutput("rst_mid_instr", out_fetch_instr, 32'd0);
    checkOutput("rst_mid_mem_addr", out_mem_addr, 32'd0);
    checkOutput("rst_mid_ready", 32'(out_fetch_ready), 32'd1);
    in_mem_valid = 1'b1;
    in_mem_instr = 32'hCAFE_F00D;
    step();
    in_mem_valid = 1'b0;
    step();
  endtask

  // Monitor: every response pulse must match the oldest expected instruction,
  // and a held memory request must carry the oldest expected miss address.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_fetch_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_fetch_valid: got pulse with 0x%08h, expected no response",
                   out_fetch_instr);
        end else begin
          checkOutput("fetch_instr", out_fetch_instr, resp_q.pop_front());
        end
      end
      if (out_mem_req === 1'b1) begin
        if (req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_mem_req: got request for 0x%08h, expected none",
                   out_mem_addr);
        end else begin
          checkOutput("mem_addr", out_mem_addr, req_q[0]);
        end
      end else if (prev_req && req_q.size() > 0) begin
        void'(req_q.pop_front());
      end
      prev_req = (out_mem_req === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    in_fetch_valid = 1'b0;
    in_fetch_pc    = '0;
    in_mem_valid   = 1'b0;
    in_mem_instr   = '0;
    in_misbranch   = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    checkOutput("reset_fetch_valid", 32'(out_fetch_valid), 32'd0);
    checkOutput("reset_mem_req", 32'(out_mem_req), 32'd0);
    checkOutput("reset_instr", out_fetch_instr, 32'd0);
    checkOutput("reset_mem_addr", out_mem_addr, 32'd0);
    checkOutput("reset_ready", 32'(out_fetch_ready), 32'd1);
    mon_en = 1'b1;

    $display("[TB] cold miss and back-to-back hits");
    mem_over[32'h100] = 32'h0000_0513;
    applyStimulus(32'h0000_0100, 3, 0, 0);
    applyStimulus(32'h0000_0100, 0, 0, 0);
    applyStimulus(32'h0000_0100, 0, 0, 0);

    $display("[TB] conflict eviction");
    mem_over[32'h100] = 32'h1111_1111;
    mem_over[32'h500] = 32'h2222_2222;
    applyStimulus(32'h0000_0500, 1, 0, 0);
    applyStimulus(32'h0000_0100, 2, 0, 0);
    applyStimulus(32'h0000_0500, 0, 0, 0);
    applyStimulus(32'h0000_0103, 1, 0, 0);

    $display("[TB] misbranch");
    mem_over[32'h200] = 32'hDEAD_BEEF;
    applyStimulus(32'h0000_0200, 2, 2, 0);
    applyStimulus(32'h0000_0200, 1, 0, 0);
    applyStimulus(32'h0000_0200, 0, 1, 0);
    applyStimulus(32'h0000_0201, 0, 0, 0);

    $display("[TB] rdy stall during miss");
    applyStimulus(32'h0000_0A04, 1, 0, 4);
    applyStimulus(32'h0000_0A04, 0, 0, 0);

    $display("[TB] reset mid-miss");
    resetMidMiss();
    applyStimulus(32'h0000_0100, 1, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      logic [7:0]  ridx;
      logic [21:0] rtag;
      logic [31:0] pc;
      int          r;
      case ($urandom_range(0, 3))
        0:       ridx = 8'h00;
        1:       ridx = 8'h40;
        2:       ridx = 8'h41;
        default: ridx = 8'hFF;
      endcase
      case ($urandom_range(0, 2))
        0:       rtag = 22'h0;
        1:       rtag = 22'h1;
        default: rtag = 22'h3F_FFFF;
      endcase
      pc = {rtag, ridx, 2'($urandom_range(0, 3))};
      r  = int'($urandom_range(0, 9));
      applyStimulus(pc, int'($urandom_range(0, 3)),
                    (r == 0) ? 1 : ((r == 1) ? 2 : 0),
                    (r == 2) ? int'($urandom_range(1, 3)) : 0);
    end

    step();
    step();
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache. Sits between the fetcher and memCtrl on the instruction-fetch path.
- Serves one 32-bit instruction per fetch request.
- On a hit it answers from its array. On a miss it issues one word request to memCtrl, fills the line and then answers.
- A rob misbranch aborts any in-flight miss. Array contents are kept, since instruction memory is never written.

Parameters:
- LINES, 256, number of one-word lines; power of two.
- INDEX_WIDTH, 8, log2(LINES).
- ADDR_WIDTH, 32, PC/address width.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-2 (=22), stored tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state and outputs
- in_fetch_valid  in  1  fetcher request strobe; sampled only when out_fetch_ready=1
- in_fetch_pc  in  ADDR_WIDTH  request PC, word aligned
- out_fetch_ready  out  1  cache is IDLE and can accept a request
- out_fetch_valid  out  1  one-cycle pulse; out_fetch_instr is valid
- out_fetch_instr  out  32  instruction for the accepted PC
- out_mem_req  out  1  miss fetch request, held until in_mem_valid
- out_mem_addr  out  ADDR_WIDTH  word-aligned miss address
- in_mem_valid  in  1  memCtrl returns the miss word (one-cycle pulse)
- in_mem_instr  in  32  returned word
- in_misbranch  in  1  rob flush

Behaviour:
- Address split:
  - index = pc[INDEX_WIDTH+1:2]
  - tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2]
  - pc[1:0] ignored.
- Storage: valid[LINES], tag[LINES], data[LINES].
- Reset (rst=1 at a clk edge):
  - all valid bits cleared, state=IDLE.
  - out_fetch_valid=0, out_mem_req=0, out_fetch_instr=0, out_mem_addr=0.
  - out_fetch_ready=1 from the cycle after reset.
  - Reset mid-miss drops the miss; a later in_mem_valid is ignored while IDLE.
- rdy=0: no state, array or output register changes. rdy takes precedence over everything except rst.
- State IDLE (out_fetch_ready=1):
  - in_fetch_valid=1 and hit (valid[index] && tag match):
    - next cycle out_fetch_valid=1 with data[index]; stay IDLE.
    - 1-cycle hit latency; back-to-back hits are accepted every cycle.
  - in_fetch_valid=1 and miss:
    - latch pc; next cycle out_mem_req=1 with out_mem_addr={pc[31:2],2'b00}; go to MISS.
  - in_mem_valid while IDLE is ignored.
- State MISS (out_fetch_ready=0):
  - out_mem_req and out_mem_addr are held stable.
  - in_fetch_valid is ignored.
  - On in_mem_valid in cycle M:
    - write data/tag and set valid at the latched index (overwrites any previous line: conflict eviction).
    - cycle M+1: out_fetch_valid=1 with in_mem_instr, out_mem_req=0, state IDLE.
  - New requests are accepted from cycle M+1.
- out_fetch_valid is a single-cycle pulse. out_fetch_instr holds its last value otherwise.
- in_misbranch=1 (priority over everything except rst/rdy):
  - next cycle state=IDLE, out_mem_req=0, out_fetch_valid=0.
  - the latched miss is discarded; no array write, even if in_mem_valid arrives in the same cycle.
  - a hit response scheduled for the next cycle is suppressed.
  - in_fetch_valid in the same cycle is ignored.
  - out_fetch_ready=1 the cycle after.
- Only one outstanding miss at a time; no prefetch.
- PCs differing only in bits [1:0] map to the same line.

Decomposition:
- Shared defines header (alongside the existing DATA_WIDTH/RAM_ADDRESS_WIDTH defines): ICACHE_LINES, ICACHE_INDEX_WIDTH, ICACHE_TAG_WIDTH, state encodings ICACHE_IDLE/ICACHE_MISS.
- One natural sub-module: icache_array. Single-port storage of valid/tag/data with combinational read on index, synchronous write, and synchronous valid clear on rst.
- FSM and handshake stay in icache.

Test Plan:
- Cold miss:
  - after reset, request pc=0x0000_0100; memCtrl answers 3 cycles later with 0x0000_0513.
  - Required: out_mem_req=1 with addr 0x100 until in_mem_valid; out_fetch_valid one cycle later with instr 0x00000513; out_fetch_ready back to 1.
- Hit:
  - re-request pc=0x100, then pc=0x100 again on the next cycle.
  - Required: out_fetch_valid on both following cycles with 0x00000513; out_mem_req stays 0.
- Conflict eviction:
  - fill pc=0x100 (0x11111111), then pc=0x500 (same index 0x40; 0x22222222), then request 0x100.
  - Required: the last request misses; out_mem_addr=0x100.
- Misbranch mid-miss:
  - miss on pc=0x200; assert in_misbranch in the same cycle as in_mem_valid (0xDEADBEEF).
  - Required: no out_fetch_valid. A later request to 0x200 misses again, proving no fill occurred.
- rdy stall:
  - drop rdy for 4 cycles while in MISS with in_mem_valid low.
  - Required: out_mem_req and out_mem_addr unchanged; after rdy returns, normal completion.
- Reset mid-miss:
  - assert rst during MISS, then pulse in_mem_valid.
  - Required: all outputs 0, out_fetch_ready=1, no out_fetch_valid. A previously filled pc misses (valid cleared).
